instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding ROM requester feeding a 2-word prefetch
// buffer, with redirect (absolute or PC-relative) and discard of in-flight responses.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] MAB,
    output logic        rom_rd,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic [15:0] MDB_out,
    output logic        mdb_valid,
    input  logic        dec_ready,
    input  logic        redir,
    input  logic        redir_rel,
    input  logic [15:0] redir_addr,
    input  logic [9:0]  redir_off,
    output logic [15:0] PC_out
);

    localparam logic [15:0] RESET_WORD = {RESET_PC[15:1], 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] mab_reg, mab_next;
    logic [15:0] fetch_ptr_reg, fetch_ptr_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] last_pc_reg, last_pc_next;
    logic [15:0] pend_reg, pend_next;
    logic [15:0] buf_reg [2];
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [1:0]  count_reg, count_next;

    logic        pop, accept, push;
    logic [15:0] rel_target, target_raw, target;

    assign pop    = (count_reg != 2'd0) && dec_ready;
    assign accept = (state_reg == REQ) && rom_ack;
    // A response landing on a redirect edge belongs to the old stream.
    assign push   = accept && !redir;

    // Relative target uses last_pc before any pop on this edge.
    assign rel_target = last_pc_reg + 16'd2 + {{5{redir_off[9]}}, redir_off, 1'b0};
    assign target_raw = redir_rel ? rel_target : redir_addr;
    assign target     = target_raw & 16'hFFFE;

    always_comb begin
        count_next = count_reg;
        if (redir) begin
            count_next = 2'd0;
        end else begin
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (count_next != 2'd2) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redir) begin
                    state_next = rom_ack ? REQ : DROP;
                end else if (rom_ack) begin
                    state_next = (count_next != 2'd2) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (rom_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rom_rd = (state_reg != IDLE);
    end

    always_comb begin
        fetch_ptr_next = fetch_ptr_reg;
        if (redir) begin
            fetch_ptr_next = target;
        end else if (push) begin
            fetch_ptr_next = fetch_ptr_reg + 16'd2;
        end
    end

    always_comb begin
        pend_next = redir ? target : pend_reg;
    end

    // MAB only moves when a fresh request is launched; it is frozen through DROP.
    always_comb begin
        mab_next = mab_reg;
        if (state_next == REQ) begin
            if ((state_reg == DROP) && !redir) begin
                mab_next = pend_reg;
            end else begin
                mab_next = fetch_ptr_next;
            end
        end
    end

    always_comb begin
        pc_next      = pc_reg;
        last_pc_next = last_pc_reg;
        if (pop) begin
            last_pc_next = pc_reg;
            pc_next      = pc_reg + 16'd2;
        end
        if (redir) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mab_reg       <= RESET_WORD;
            fetch_ptr_reg <= RESET_WORD;
            pc_reg        <= RESET_WORD;
            last_pc_reg   <= RESET_WORD;
            pend_reg      <= 16'd0;
            count_reg     <= 2'd0;
        end else begin
            mab_reg       <= mab_next;
            fetch_ptr_reg <= fetch_ptr_next;
            pc_reg        <= pc_next;
            last_pc_reg   <= last_pc_next;
            pend_reg      <= pend_next;
            count_reg     <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redir) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg ^ push;
            rd_ptr_reg <= rd_ptr_reg ^ pop;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg[gi] <= 16'd0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    buf_reg[gi] <= rom_data;
                end
            end
        end
    endgenerate

    assign MAB       = mab_reg;
    assign MDB_out   = buf_reg[rd_ptr_reg];
    assign mdb_valid = (count_reg != 2'd0);
    assign PC_out    = pc_reg;

endmodule
